header_action: RTL

HEADER_ACTION -- requirements
Module: header_action

---
 rtl/header_action_pkg.sv | 25 ++
 rtl/header_lane_acc.sv | 94 +++++++++
 rtl/header_action.sv | 122 ++++++++++++
 3 files changed

// File: rtl/header_action_pkg.sv
// ============================================================================
// Module : header_action_pkg
// Brief  : Shared lane geometry, action codes and lane state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package header_action_pkg;

  localparam int NUM_LANES = 8;
  localparam int LANE_W    = 32;
  localparam int PKTID_W   = 8;

  localparam logic [1:0] ACT_FWD     = 2'd0;
  localparam logic [1:0] ACT_DISCARD = 2'd1;

  typedef enum logic [1:0] {
    LIDLE   = 2'd0,
    COLLECT = 2'd1,
    PENDING = 2'd2
  } lane_state_e;

endpackage

`default_nettype wire

// File: rtl/header_lane_acc.sv
// ============================================================================
// Module : header_lane_acc
// Brief  : One header lane: collects words, latches pktID, decides the action.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module header_lane_acc
  import header_action_pkg::*;
#(
  parameter int          MAX_HDR_WORDS = 16,
  parameter logic [15:0] DROP_TAG      = 16'hFFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_valid,
  input  logic [LANE_W-1:0]  i_data,
  input  logic               i_finish,
  input  logic [PKTID_W-1:0] i_pktid,
  input  logic               i_grant,
  output logic               o_pending,
  output logic               o_bid,
  output logic [1:0]         o_action,
  output logic [PKTID_W-1:0] o_pktid
);

  lane_state_e        r_state;
  lane_state_e        w_state_next;
  logic [7:0]         r_count;
  logic [7:0]         w_count_inc;
  logic [LANE_W-1:0]  r_word0;
  logic [PKTID_W-1:0] r_pktid;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= LIDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LIDLE: begin
        if (i_finish)     w_state_next = PENDING;
        else if (i_valid) w_state_next = COLLECT;
      end
      COLLECT: if (i_finish) w_state_next = PENDING;
      PENDING: if (i_grant)  w_state_next = LIDLE;
      default:               w_state_next = LIDLE;
    endcase
  end

  assign w_count_inc = (r_count == 8'hFF) ? r_count : r_count + 8'd1;

  // Count/word0 are cleared on grant so a word-less finish sees count 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
      r_word0 <= '0;
      r_pktid <= '0;
    end else begin
      case (r_state)
        LIDLE: begin
          if (i_valid) begin
            r_word0 <= i_data;
            r_count <= 8'd1;
          end
        end
        COLLECT: if (i_valid) r_count <= w_count_inc;
        PENDING: begin
          if (i_grant) begin
            r_count <= '0;
            r_word0 <= '0;
          end
        end
        default: ;
      endcase
      if ((r_state != PENDING) && i_finish) r_pktid <= i_pktid;
    end
  end

  always_comb begin
    o_action = ACT_FWD;
    if (({24'd0, r_count} > 32'(MAX_HDR_WORDS)) || (r_count == 8'd0) ||
        (r_word0[31:16] == DROP_TAG))
      o_action = ACT_DISCARD;
  end

  assign o_pending = (r_state == PENDING);
  assign o_bid     = (r_state == LIDLE);
  assign o_pktid   = r_pktid;

endmodule

`default_nettype wire

// File: rtl/header_action.sv
// ============================================================================
// Module : header_action
// Brief  : Eight header lanes, round-robin arbiter and a held command register.
//          Optional fwd/drop counters when HEADER_ACTION_STATS_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module header_action
  import header_action_pkg::*;
#(
  parameter int          MAX_HDR_WORDS = 16,
  parameter logic [15:0] DROP_TAG      = 16'hFFFF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_LANES-1:0]           headerData_valid,
  input  logic [NUM_LANES*LANE_W-1:0]    headerData,
  input  logic [NUM_LANES-1:0]           headerData_finish_valid,
  input  logic [NUM_LANES*PKTID_W-1:0]   pktID_out,
  output logic [NUM_LANES-1:0]           bid_bitmap,
  output logic                           pktID_in_valid,
  output logic [11:0]                    pktID_in,
  input  logic                           cmd_ready
`ifdef HEADER_ACTION_STATS_EN
  ,
  output logic [31:0]                    fwd_count,
  output logic [31:0]                    drop_count
`endif
);

  localparam int c_PTR_W = $clog2(NUM_LANES);

  logic [NUM_LANES-1:0] w_pending;
  logic [NUM_LANES-1:0] w_bid;
  logic [NUM_LANES-1:0] w_grant;
  logic [1:0]           w_action [NUM_LANES];
  logic [PKTID_W-1:0]   w_pktid  [NUM_LANES];

  logic [c_PTR_W-1:0]   r_ptr;
  logic [c_PTR_W-1:0]   w_scan;
  logic [c_PTR_W-1:0]   w_gnt_idx;
  logic                 w_gnt_any;
  logic                 w_take;
  logic                 r_valid;
  logic [11:0]          r_cmd;

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    header_lane_acc #(
      .MAX_HDR_WORDS (MAX_HDR_WORDS),
      .DROP_TAG      (DROP_TAG)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .i_valid   (headerData_valid[j]),
      .i_data    (headerData[LANE_W*j +: LANE_W]),
      .i_finish  (headerData_finish_valid[j]),
      .i_pktid   (pktID_out[PKTID_W*j +: PKTID_W]),
      .i_grant   (w_grant[j]),
      .o_pending (w_pending[j]),
      .o_bid     (w_bid[j]),
      .o_action  (w_action[j]),
      .o_pktid   (w_pktid[j])
    );
  end

  // First pending lane at or after r_ptr, wrapping through the last lane.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_scan = r_ptr + i[c_PTR_W-1:0];
      if (!w_gnt_any && w_pending[w_scan]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_scan;
      end
    end
  end

  assign w_take  = w_gnt_any && (!r_valid || cmd_ready);
  assign w_grant = w_take ? (NUM_LANES'(1) << w_gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_cmd   <= '0;
      r_ptr   <= '0;
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_cmd   <= {2'b00, w_action[w_gnt_idx], w_pktid[w_gnt_idx]};
      r_ptr   <= w_gnt_idx + 1'b1;
    end else if (cmd_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bid_bitmap     = w_bid;
  assign pktID_in_valid = r_valid;
  assign pktID_in       = r_cmd;

`ifdef HEADER_ACTION_STATS_EN
  logic [31:0] r_fwd_count;
  logic [31:0] r_drop_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fwd_count  <= '0;
      r_drop_count <= '0;
    end else if (r_valid && cmd_ready) begin
      if (r_cmd[9:8] == ACT_FWD)          r_fwd_count  <= r_fwd_count + 32'd1;
      else if (r_cmd[9:8] == ACT_DISCARD) r_drop_count <= r_drop_count + 32'd1;
    end
  end

  assign fwd_count  = r_fwd_count;
  assign drop_count = r_drop_count;
`endif

endmodule

`default_nettype wire
